hazard_unit: RTL and testbench

//  Consumer end of the pipelined controller's hazard interface: takes ResultSrcE0, PCSrcE,

---
 rtl/hazard_pkg.sv | 37 +++
 rtl/hz_perf_cnt.sv | 43 ++++
 rtl/hazard_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the RVX10-P hazard unit.
//   fwd_sel_t  : operand forwarding select driven onto the SrcA/SrcB muxes
//   mc_state_t : multi-cycle execute handshake state
//   fwd_sel()  : forwarding priority (M-stage result is younger, so it wins over W)
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // x0 is hard-wired zero, so a write to it never produces a forwardable value.
  function automatic fwd_sel_t fwd_sel(
    input logic       regwrite_m,
    input logic [4:0] rd_m,
    input logic       regwrite_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs_e
  );
    fwd_sel_t sel;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hz_perf_cnt.sv
// Wrapping performance counter.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset (count -> 0)
//   clr_i  : synchronous clear; takes priority over en_i in the same cycle
//   en_i   : count this cycle
//   cnt_o  : current count, wraps modulo 2^CNT_W
module hz_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// RVX10-P hazard unit: forwarding selects, load-use stall, branch flush, and a
// multi-cycle execute handshake with timeout, plus three perf counters.
//   Inputs : clk_i, reset_i (async, active-high), Decode/Execute source regs,
//            E/M/W dest regs, ResultSrcE0_i (load in E), PCSrcE_i (taken in E),
//            RegWriteM_i/W_i, McStartE_i/McDoneE_i handshake, PerfClr_i.
//   Outputs: StallF/D/E, FlushD/E/M, ForwardAE/BE, sticky McErr_o,
//            StallCnt_o, LoadUseCnt_o, FlushCnt_o.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       Rs1D_i,
  input  logic [4:0]       Rs2D_i,
  input  logic [4:0]       Rs1E_i,
  input  logic [4:0]       Rs2E_i,
  input  logic [4:0]       RdE_i,
  input  logic [4:0]       RdM_i,
  input  logic [4:0]       RdW_i,
  input  logic             ResultSrcE0_i,
  input  logic             PCSrcE_i,
  input  logic             RegWriteM_i,
  input  logic             RegWriteW_i,
  input  logic             McStartE_i,
  input  logic             McDoneE_i,
  input  logic             PerfClr_i,
  output logic             StallF_o,
  output logic             StallD_o,
  output logic             StallE_o,
  output logic             FlushD_o,
  output logic             FlushE_o,
  output logic             FlushM_o,
  output logic [1:0]       ForwardAE_o,
  output logic [1:0]       ForwardBE_o,
  output logic             McErr_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] LoadUseCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam int             EL_W    = $clog2(MC_TIMEOUT);
  localparam logic [EL_W-1:0] EL_LAST = EL_W'(MC_TIMEOUT - 1);

  mc_state_t        state_q, state_d;
  logic [EL_W-1:0]  elapsed_q, elapsed_d;
  logic             mc_err_q, mc_err_d;
  logic             mc_stall_s;
  logic             lw_stall_s;

  assign ForwardAE_o = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs1E_i);
  assign ForwardBE_o = fwd_sel(RegWriteM_i, RdM_i, RegWriteW_i, RdW_i, Rs2E_i);

  assign lw_stall_s = ResultSrcE0_i && (RdE_i != 5'd0) &&
                      ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));

  // Multi-cycle handshake next state. The stall is raised combinationally on
  // the start cycle so a same-cycle done costs nothing; on timeout the stall
  // drops in the final busy cycle and the datapath discards the result.
  always_comb begin
    state_d    = state_q;
    elapsed_d  = elapsed_q;
    mc_err_d   = mc_err_q;
    mc_stall_s = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (McStartE_i && !McDoneE_i) begin
          state_d    = MC_BUSY;
          elapsed_d  = {EL_W{1'b0}};
          mc_stall_s = 1'b1;
        end else begin
          state_d = MC_IDLE;
        end
      end
      MC_BUSY: begin
        if (McDoneE_i) begin
          state_d = MC_IDLE;
        end else if (elapsed_q == EL_LAST) begin
          state_d  = MC_IDLE;
          mc_err_d = 1'b1;
        end else begin
          mc_stall_s = 1'b1;
          elapsed_d  = elapsed_q + {{(EL_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d   = MC_IDLE;
        elapsed_d = {EL_W{1'b0}};
      end
    endcase
  end

  // Handshake state, elapsed counter and sticky error flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= MC_IDLE;
      elapsed_q <= {EL_W{1'b0}};
      mc_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      mc_err_q  <= mc_err_d;
    end
  end

  // A stalled E stage must keep its instruction, so flushes are suppressed
  // (and a branch decision in E is ignored) while the multi-cycle op holds E.
  assign StallF_o = lw_stall_s | mc_stall_s;
  assign StallD_o = lw_stall_s | mc_stall_s;
  assign StallE_o = mc_stall_s;
  assign FlushM_o = mc_stall_s;
  assign FlushD_o = PCSrcE_i & ~mc_stall_s;
  assign FlushE_o = (lw_stall_s | PCSrcE_i) & ~mc_stall_s;
  assign McErr_o  = mc_err_q;

  hz_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .clr_i (PerfClr_i),
    .en_i  (StallF_o),
    .cnt_o (StallCnt_o)
  );

  hz_perf_cnt #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .clr_i (PerfClr_i),
    .en_i  (lw_stall_s & ~mc_stall_s),
    .cnt_o (LoadUseCnt_o)
  );

  hz_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .clr_i (PerfClr_i),
    .en_i  (PCSrcE_i & ~mc_stall_s),
    .cnt_o (FlushCnt_o)
  );

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic ld, pc, wm, ww, mc_start, mc_done, perf_clr;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_err;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, lu_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W), .MC_TIMEOUT(8)) dut (
    .clk_i(clk), .reset_i(rst),
    .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
    .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
    .ResultSrcE0_i(ld), .PCSrcE_i(pc), .RegWriteM_i(wm), .RegWriteW_i(ww),
    .McStartE_i(mc_start), .McDoneE_i(mc_done), .PerfClr_i(perf_clr),
    .StallF_o(stall_f), .StallD_o(stall_d), .StallE_o(stall_e),
    .FlushD_o(flush_d), .FlushE_o(flush_e), .FlushM_o(flush_m),
    .ForwardAE_o(fwd_a), .ForwardBE_o(fwd_b), .McErr_o(mc_err),
    .StallCnt_o(stall_cnt), .LoadUseCnt_o(lu_cnt), .FlushCnt_o(flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       ld, pc, wm, ww;
    logic [1:0] fa, fb;
    logic       stall, fd, fe;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0;
    rde = 5'd0; rdm = 5'd0; rdw = 5'd0;
    ld = 1'b0; pc = 1'b0; wm = 1'b0; ww = 1'b0;
    mc_start = 1'b0; mc_done = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
  endtask

  logic [9:0] exp_pk;
  int n_stall;
  bit released;

  initial begin
    clear_inputs();
    //              rs1d   rs2d   rs1e   rs2e   rde    rdm    rdw    ld    pc    wm    ww    fa     fb     stl   fd    fe
    vecs[0] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd0, 5'd0, 5'd5, 5'd6, 5'd0, 5'd5, 5'd6, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd0, 5'd0, 5'd4, 5'd9, 5'd0, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    vecs[9] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    #12;
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_outputs", {22'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a, fwd_b}, 32'd0);
    check("rst_mc_err", {31'd0, mc_err}, 32'd0);
    check("rst_cnts", stall_cnt | lu_cnt | flush_cnt, 32'd0);

    // Combinational table
    for (int i = 0; i < 10; i++) begin
      rs1d = vecs[i].rs1d; rs2d = vecs[i].rs2d; rs1e = vecs[i].rs1e; rs2e = vecs[i].rs2e;
      rde = vecs[i].rde; rdm = vecs[i].rdm; rdw = vecs[i].rdw;
      ld = vecs[i].ld; pc = vecs[i].pc; wm = vecs[i].wm; ww = vecs[i].ww;
      #1;
      exp_pk = {vecs[i].stall, vecs[i].stall, 1'b0, vecs[i].fd, vecs[i].fe, 1'b0, vecs[i].fa, vecs[i].fb};
      check($sformatf("vec%0d", i),
            {22'd0, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, fwd_a, fwd_b},
            {22'd0, exp_pk});
      tick();
    end

    // Load-use stall counts once
    do_reset();
    ld = 1'b1; rde = 5'd7; rs2d = 5'd7;
    #1;
    check("lu_flushd", {31'd0, flush_d}, 32'd0);
    tick();
    clear_inputs();
    check("lu_cnt", lu_cnt, 32'd1);
    check("lu_stall_cnt", stall_cnt, 32'd1);

    // Taken branch for one cycle
    do_reset();
    pc = 1'b1;
    #1;
    check("br_outputs", {29'd0, stall_f, flush_d, flush_e}, {29'd0, 3'b011});
    tick();
    clear_inputs();
    check("br_flush_cnt", flush_cnt, 32'd1);
    check("br_stall_cnt", stall_cnt, 32'd0);

    // Multi-cycle op, done after 4 stall cycles; branch in E ignored while stalled
    do_reset();
    mc_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      pc = (c == 1) ? 1'b1 : 1'b0;
      #1;
      check($sformatf("mc_stall_c%0d", c), {28'd0, stall_f, stall_d, stall_e, flush_m}, 32'hF);
      if (c == 1) check("mc_pc_ignored", {30'd0, flush_d, flush_e}, 32'd0);
      tick();
    end
    pc = 1'b0;
    mc_done = 1'b1;
    #1;
    check("mc_done_cycle", {28'd0, stall_f, stall_d, stall_e, flush_m}, 32'd0);
    tick();
    clear_inputs();
    check("mc_stall_cnt", stall_cnt, 32'd4);
    check("mc_flush_cnt", flush_cnt, 32'd0);

    // Start and done in the same cycle: no stall
    mc_start = 1'b1; mc_done = 1'b1;
    #1;
    check("mc_same_cycle", {28'd0, stall_f, stall_d, stall_e, flush_m}, 32'd0);
    tick();
    clear_inputs();
    check("mc_same_cnt", stall_cnt, 32'd4);

    // Timeout (MC_TIMEOUT=8): load-use during busy must not flush E nor count
    do_reset();
    mc_start = 1'b1;
    n_stall = 0;
    released = 1'b0;
    for (int c = 0; c < 20 && !released; c++) begin
      if (c >= 2 && c <= 4) begin
        ld = 1'b1; rde = 5'd7; rs1d = 5'd7;
      end else begin
        ld = 1'b0; rde = 5'd0; rs1d = 5'd0;
      end
      #1;
      if (stall_e) begin
        n_stall++;
        if (c == 3) check("to_lw_noflush", {30'd0, flush_e, stall_f}, 32'd1);
      end else begin
        released = 1'b1;
      end
      tick();
    end
    clear_inputs();
    check("to_released", {31'd0, released}, 32'd1);
    check("to_stall_cycles", n_stall, 32'd8);
    check("to_mc_err", {31'd0, mc_err}, 32'd1);
    check("to_stall_cnt", stall_cnt, 32'd8);
    check("to_lu_cnt", lu_cnt, 32'd0);
    tick();
    check("to_err_sticky", {31'd0, mc_err}, 32'd1);

    // Async reset in the middle of MC_BUSY
    mc_start = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    mc_start = 1'b0;
    #1;
    check("ar_stall_e", {31'd0, stall_e}, 32'd0);
    check("ar_mc_err", {31'd0, mc_err}, 32'd0);
    check("ar_cnts", stall_cnt | lu_cnt | flush_cnt, 32'd0);
    rst = 1'b0;
    tick();
    check("ar_idle", {31'd0, stall_e}, 32'd0);

    // PerfClr beats an active stall increment
    mc_start = 1'b1;
    tick();
    tick();
    check("pc_pre_cnt", stall_cnt, 32'd2);
    perf_clr = 1'b1;
    #1;
    check("pc_stall_live", {31'd0, stall_f}, 32'd1);
    tick();
    perf_clr = 1'b0;
    check("pc_cleared", stall_cnt, 32'd0);
    tick();
    check("pc_resume", stall_cnt, 32'd1);
    clear_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
